// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-read-port register file: clear-sequencer
// state encodings and the debug view of the sequencer.
package regfile_mp_pkg;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    typedef struct packed {
        logic [0:0] state;
        logic       ready;
        logic       clr_we;
    } clr_dbg_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: one write port, NUM_RD
// packed read ports and the clear handshake.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    // ready=1 means the array is idle: we and clear_req are honoured only in
    // that cycle; with ready=0 both are ignored, nothing is queued.
    logic                       clear_req;
    logic                       ready;
    logic                       we;
    logic [ADDR_W-1:0]          waddr;
    logic [DATA_W-1:0]          wdata;
    logic [NUM_RD*ADDR_W-1:0]   raddr;
    logic [NUM_RD*DATA_W-1:0]   rdata;

    modport master (
        output clear_req, we, waddr, wdata, raddr,
        input  ready, rdata
    );

    modport slave (
        input  clear_req, we, waddr, wdata, raddr,
        output ready, rdata
    );
endinterface

// File: rtl/regfile_mp_clear_fsm.sv
// Clear sequencer: sweeps zeros through every entry after reset or on
// request, and owns the ready flag.
module regfile_mp_clear_fsm
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic [0:0]        state,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    logic [0:0]        state_q;
    logic [ADDR_W-1:0] ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    assign state    = state_q;
    assign ready    = (state_q == ST_IDLE);
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NUM_RD registered read ports, one write
// port, optional write-to-read bypass and optional hardwired-zero r0.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic      clk,
    input  logic      rst,
    regfile_mp_if.slave bus,
    output clr_dbg_t  dbg
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [0:0]        clr_state;
    logic              clr_ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_acc;
    logic [NUM_RD*DATA_W-1:0] rdata_all;

    logic [DATA_W-1:0] mem [DEPTH];

    regfile_mp_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clear_req(bus.clear_req),
        .state    (clr_state),
        .ready    (clr_ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A clear request in the same cycle wins over the write.
    always_comb begin
        wr_acc = clr_ready && !bus.clear_req && bus.we;
        if ((ZERO_REG != 0) && (bus.waddr == '0)) begin
            wr_acc = 1'b0;
        end
    end

    // Single muxed write port keeps the array mappable to distributed RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_q;

        assign ra = bus.raddr[p*ADDR_W +: ADDR_W];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_q <= '0;
            end else if (clr_we) begin
                rd_q <= '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_q <= '0;
            end else if ((BYPASS != 0) && wr_acc && (bus.waddr == ra)) begin
                rd_q <= bus.wdata;
            end else begin
                rd_q <= mem[ra];
            end
        end

        assign rdata_all[p*DATA_W +: DATA_W] = rd_q;
    end

    assign bus.rdata  = rdata_all;
    assign bus.ready  = clr_ready;
    assign dbg.state  = clr_state;
    assign dbg.ready  = clr_ready;
    assign dbg.clr_we = clr_we;

endmodule
